eth_tx_arbiter: RTL and testbench

Two-requester transmit scheduler in front of the 10G Ethernet TX datapath inside `eth_top`. It grants the 64-bit AXI-Stream TX path to one requester per whole frame, alternates grants round-robin, and enforces a programmable idle gap (`ifg_len` cycles) between consecutive frames. It also keeps per-requester transmitted-frame counters for status readout.

---
 rtl/eth_tx_arbiter_if.sv | 26 ++
 rtl/eth_tx_arbiter.sv | 166 ++++++++++++++++
 tb/tb_eth_tx_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_arbiter_if.sv
// 64-bit AXI-Stream beat bundle. It is shared by the two TX requesters and the
// MAC TX side of eth_tx_arbiter. The master modport drives a beat and the
// slave modport accepts it.
interface eth_tx_arbiter_if;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast;
    logic        tvalid;
    logic        tready;

    modport master (
        output tdata,
        output tkeep,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tlast,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: a two-requester frame scheduler in front of the 10G MAC TX.
// It grants the TX stream to one requester for a whole frame. Grants alternate
// round-robin when both requesters ask at once. After every frame it holds an
// idle gap of ifg_len cycles. It also counts completed frames per requester.
//
// The data path is a purely combinational mux while a frame is in flight, so
// no beat is ever stored inside the block. The state register and the grant,
// busy and counter outputs are all registered.
module eth_tx_arbiter #(
    parameter logic [27:0] ifg_len = 28'hF
) (
    input  logic                 user_clk,
    input  logic                 cold_reset,
    input  logic                 en,
    eth_tx_arbiter_if.slave      s0,
    eth_tx_arbiter_if.slave      s1,
    eth_tx_arbiter_if.master     m,
    output logic                 grant,
    output logic                 busy,
    output logic [31:0]          frm_cnt0,
    output logic [31:0]          frm_cnt1
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_IFG  = 2'd2
    } state_t;

    state_t       state_r;
    logic         grant_r;
    logic         busy_r;
    logic         last_served_r;
    logic [27:0]  ifg_cnt_r;
    logic [31:0]  frm_cnt0_r;
    logic [31:0]  frm_cnt1_r;

    logic         xfer_s;
    logic         pick_s;
    logic         any_req_s;
    logic [63:0]  mux_tdata_s;
    logic [7:0]   mux_tkeep_s;
    logic         mux_tlast_s;
    logic         mux_tvalid_s;
    logic         s0_tready_s;
    logic         s1_tready_s;
    logic         frame_done_s;

    assign xfer_s    = (state_r == ST_XFER);
    assign any_req_s = s0.tvalid | s1.tvalid;

    // Arbitration choice: on a tie the requester not served last wins, otherwise the lone requester wins
    always_comb begin
        pick_s = 1'b0;
        if (s0.tvalid && s1.tvalid) begin
            pick_s = ~last_served_r;
        end else if (s1.tvalid) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end
    end

    // Zero-latency stream mux; everything is forced to zero outside a frame transfer
    always_comb begin
        mux_tdata_s  = 64'd0;
        mux_tkeep_s  = 8'd0;
        mux_tlast_s  = 1'b0;
        mux_tvalid_s = 1'b0;
        s0_tready_s  = 1'b0;
        s1_tready_s  = 1'b0;
        if (xfer_s) begin
            if (grant_r) begin
                mux_tdata_s  = s1.tdata;
                mux_tkeep_s  = s1.tkeep;
                mux_tlast_s  = s1.tlast;
                mux_tvalid_s = s1.tvalid;
                s1_tready_s  = m.tready;
            end else begin
                mux_tdata_s  = s0.tdata;
                mux_tkeep_s  = s0.tkeep;
                mux_tlast_s  = s0.tlast;
                mux_tvalid_s = s0.tvalid;
                s0_tready_s  = m.tready;
            end
        end else begin
            mux_tdata_s  = 64'd0;
            mux_tkeep_s  = 8'd0;
            mux_tlast_s  = 1'b0;
            mux_tvalid_s = 1'b0;
            s0_tready_s  = 1'b0;
            s1_tready_s  = 1'b0;
        end
    end

    // The frame ends when the beat that carries tlast is accepted by the MAC
    assign frame_done_s = xfer_s & mux_tvalid_s & m.tready & mux_tlast_s;

    assign m.tdata   = mux_tdata_s;
    assign m.tkeep   = mux_tkeep_s;
    assign m.tlast   = mux_tlast_s;
    assign m.tvalid  = mux_tvalid_s;
    assign s0.tready = s0_tready_s;
    assign s1.tready = s1_tready_s;

    assign grant     = grant_r;
    assign busy      = busy_r;
    assign frm_cnt0  = frm_cnt0_r;
    assign frm_cnt1  = frm_cnt1_r;

    // Scheduler FSM: it grants in IDLE, forwards one whole frame in XFER, then waits ifg_len cycles in IFG
    always_ff @(posedge user_clk or posedge cold_reset) begin
        if (cold_reset) begin
            state_r       <= ST_IDLE;
            grant_r       <= 1'b0;
            busy_r        <= 1'b0;
            last_served_r <= 1'b1;
            ifg_cnt_r     <= 28'd0;
            frm_cnt0_r    <= 32'd0;
            frm_cnt1_r    <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (en && any_req_s) begin
                        state_r <= ST_XFER;
                        grant_r <= pick_s;
                        busy_r  <= 1'b1;
                    end
                end
                ST_XFER: begin
                    if (frame_done_s) begin
                        last_served_r <= grant_r;
                        busy_r        <= 1'b0;
                        if (grant_r) begin
                            frm_cnt1_r <= frm_cnt1_r + 32'd1;
                        end else begin
                            frm_cnt0_r <= frm_cnt0_r + 32'd1;
                        end
                        if (ifg_len == 28'd0) begin
                            state_r   <= ST_IDLE;
                            ifg_cnt_r <= 28'd0;
                        end else begin
                            state_r   <= ST_IFG;
                            ifg_cnt_r <= ifg_len;
                        end
                    end
                end
                ST_IFG: begin
                    // A count of 1 means this is the last idle-gap cycle
                    if (ifg_cnt_r <= 28'd1) begin
                        state_r   <= ST_IDLE;
                        ifg_cnt_r <= 28'd0;
                    end else begin
                        ifg_cnt_r <= ifg_cnt_r - 28'd1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy_r    <= 1'b0;
                    ifg_cnt_r <= 28'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Self-checking bench for eth_tx_arbiter.
// Random frames come from two requester models. A transaction-level reference
// works out which requester may start when and who wins each grant. It uses
// three things: the cycle the last frame finished, the idle-gap length, and
// the owner of the previous frame. A second instance with ifg_len=0 covers
// counter wrap and back-to-back spacing.
module tb_eth_tx_arbiter;

    localparam logic [27:0] IFG = 28'd15;

    logic        user_clk;
    logic        cold_reset;
    logic        en;
    logic        grant;
    logic        busy;
    logic [31:0] frm_cnt0;
    logic [31:0] frm_cnt1;
    logic        z_grant;
    logic        z_busy;
    logic [31:0] z_frm_cnt0;
    logic [31:0] z_frm_cnt1;

    eth_tx_arbiter_if s0_if ();
    eth_tx_arbiter_if s1_if ();
    eth_tx_arbiter_if m_if ();
    eth_tx_arbiter_if z_s0_if ();
    eth_tx_arbiter_if z_s1_if ();
    eth_tx_arbiter_if z_m_if ();

    eth_tx_arbiter #(.ifg_len(IFG)) dut (
        .user_clk   (user_clk),
        .cold_reset (cold_reset),
        .en         (en),
        .s0         (s0_if),
        .s1         (s1_if),
        .m          (m_if),
        .grant      (grant),
        .busy       (busy),
        .frm_cnt0   (frm_cnt0),
        .frm_cnt1   (frm_cnt1)
    );

    eth_tx_arbiter #(.ifg_len(28'd0)) dut_z (
        .user_clk   (user_clk),
        .cold_reset (cold_reset),
        .en         (en),
        .s0         (z_s0_if),
        .s1         (z_s1_if),
        .m          (z_m_if),
        .grant      (z_grant),
        .busy       (z_busy),
        .frm_cnt0   (z_frm_cnt0),
        .frm_cnt1   (z_frm_cnt1)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: expected ownership, the earliest cycle a grant may be sampled, counters
    bit          exp_busy;
    bit          exp_grant;
    bit          last_srv;
    logic [31:0] exp_cnt [2];
    longint      cyc;
    longint      elig;
    int          bif;

    // Requester models: pending beats as {last, keep, data}, plus the values driven now
    logic [72:0] q0[$];
    logic [72:0] q1[$];
    bit          src_v [2];
    logic [63:0] d_data [2];
    logic [7:0]  d_keep [2];
    logic        d_last [2];
    int          fr_no = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit pick(input bit v0, input bit v1, input bit last);
        if (v0 && v1) return ~last;
        return v1;
    endfunction

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [72:0] qhead(input int i);
        return (i == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpop(input int i);
        if (i == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    task automatic gen_frame(input int i);
        int          len;
        logic        lst;
        logic [7:0]  kp;
        logic [72:0] b;
        len = $urandom_range(1, 8);
        fr_no++;
        for (int k = 0; k < len; k++) begin
            lst = (k == len - 1);
            kp  = lst ? 8'($urandom_range(1, 255)) : 8'hFF;
            b   = {lst, kp, 8'(i), 8'(fr_no), 16'(k), 32'($urandom)};
            if (i == 0) q0.push_back(b);
            else        q1.push_back(b);
        end
    endtask

    task automatic drive_src();
        s0_if.tvalid = src_v[0];
        s0_if.tdata  = d_data[0];
        s0_if.tkeep  = d_keep[0];
        s0_if.tlast  = d_last[0];
        s1_if.tvalid = src_v[1];
        s1_if.tdata  = d_data[1];
        s1_if.tkeep  = d_keep[1];
        s1_if.tlast  = d_last[1];
    endtask

    task automatic model_reset();
        exp_busy   = 1'b0;
        exp_grant  = 1'b0;
        last_srv   = 1'b1;
        exp_cnt[0] = 32'd0;
        exp_cnt[1] = 32'd0;
        elig       = 0;
        bif        = 0;
    endtask

    // Reset is asserted between clock edges, so the outputs must drop without waiting for a clock edge
    task automatic do_reset();
        @(negedge user_clk);
        cold_reset = 1'b1;
        #1;
        chk_eq("rst_busy",     busy,         64'd0);
        chk_eq("rst_grant",    grant,        64'd0);
        chk_eq("rst_m_tvalid", m_if.tvalid,  64'd0);
        chk_eq("rst_m_tdata",  m_if.tdata,   64'd0);
        chk_eq("rst_m_tkeep",  m_if.tkeep,   64'd0);
        chk_eq("rst_m_tlast",  m_if.tlast,   64'd0);
        chk_eq("rst_s0_tready", s0_if.tready, 64'd0);
        chk_eq("rst_s1_tready", s1_if.tready, 64'd0);
        chk_eq("rst_cnt0",     frm_cnt0,     64'd0);
        chk_eq("rst_cnt1",     frm_cnt1,     64'd0);
        q0.delete();
        q1.delete();
        for (int i = 0; i < 2; i++) begin
            src_v[i]  = 1'b0;
            d_data[i] = 64'd0;
            d_keep[i] = 8'd0;
            d_last[i] = 1'b0;
        end
        drive_src();
        repeat (2) @(negedge user_clk);
        cold_reset = 1'b0;
        model_reset();
    endtask

    // One clock cycle. mode 0 is fully random, mode 1 holds en low, mode 2 keeps both requesters busy with en and tready high
    task automatic step(input int mode);
        logic [72:0] hd;
        bit          g;
        @(negedge user_clk);
        cyc++;
        en           = (mode == 1) ? 1'b0 : ((mode == 2) ? 1'b1 : ($urandom_range(0, 9) != 0));
        m_if.tready  = (mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
        for (int i = 0; i < 2; i++) begin
            if (qsize(i) == 0 && (mode == 2 || (mode == 1 && i == 0) || $urandom_range(0, 3) == 0))
                gen_frame(i);
            if (qsize(i) != 0) begin
                if (!src_v[i]) src_v[i] = (mode != 0) || ($urandom_range(0, 2) != 0);
                hd        = qhead(i);
                d_data[i] = hd[63:0];
                d_keep[i] = hd[71:64];
                d_last[i] = hd[72];
            end else begin
                src_v[i]  = 1'b0;
                d_data[i] = {$urandom, $urandom};
                d_keep[i] = 8'($urandom);
                d_last[i] = 1'($urandom);
            end
        end
        drive_src();
        #1;
        g = exp_grant;
        chk_eq("busy", busy, exp_busy);
        chk_eq("cnt0", frm_cnt0, exp_cnt[0]);
        chk_eq("cnt1", frm_cnt1, exp_cnt[1]);
        if (exp_busy) begin
            chk_eq("grant",     grant,        g);
            chk_eq("m_tvalid",  m_if.tvalid,  src_v[g]);
            chk_eq("m_tdata",   m_if.tdata,   d_data[g]);
            chk_eq("m_tkeep",   m_if.tkeep,   d_keep[g]);
            chk_eq("m_tlast",   m_if.tlast,   d_last[g]);
            chk_eq("s0_tready", s0_if.tready, (g == 1'b0) ? m_if.tready : 1'b0);
            chk_eq("s1_tready", s1_if.tready, (g == 1'b1) ? m_if.tready : 1'b0);
        end else begin
            chk_eq("idle_tvalid", m_if.tvalid,  64'd0);
            chk_eq("idle_tdata",  m_if.tdata,   64'd0);
            chk_eq("idle_tkeep",  m_if.tkeep,   64'd0);
            chk_eq("idle_tlast",  m_if.tlast,   64'd0);
            chk_eq("idle_s0_rdy", s0_if.tready, 64'd0);
            chk_eq("idle_s1_rdy", s1_if.tready, 64'd0);
        end
        // Work out what the next cycle should look like
        if (exp_busy) begin
            if (src_v[g] && m_if.tready) begin
                qpop(g);
                src_v[g] = 1'b0;
                bif++;
                if (d_last[g]) begin
                    exp_cnt[g] = exp_cnt[g] + 32'd1;
                    last_srv   = g;
                    elig       = cyc + longint'(IFG) + 1;
                    exp_busy   = 1'b0;
                    bif        = 0;
                end
            end
        end else if (cyc >= elig && en && (src_v[0] || src_v[1])) begin
            exp_busy  = 1'b1;
            exp_grant = pick(src_v[0], src_v[1], last_srv);
            bif       = 0;
        end
    endtask

    initial begin
        int k;
        cold_reset     = 1'b1;
        en             = 1'b0;
        m_if.tready    = 1'b0;
        z_m_if.tready  = 1'b1;
        z_s0_if.tvalid = 1'b0;
        z_s0_if.tdata  = 64'd0;
        z_s0_if.tkeep  = 8'd0;
        z_s0_if.tlast  = 1'b0;
        z_s1_if.tvalid = 1'b0;
        z_s1_if.tdata  = 64'd0;
        z_s1_if.tkeep  = 8'd0;
        z_s1_if.tlast  = 1'b0;
        cyc            = 0;
        do_reset();

        // Continuous ties, then random traffic, then enable held low
        repeat (60)   step(2);
        repeat (1500) step(0);
        repeat (25)   step(1);
        repeat (300)  step(0);

        // Reset in the middle of a frame, after at least one beat has gone out
        k = 0;
        while (k < 2000 && !(exp_busy && bif > 0)) begin
            step(0);
            k++;
        end
        chk_eq("midframe_reached", (exp_busy && bif > 0), 64'd1);
        do_reset();
        repeat (60)   step(2);
        repeat (1000) step(0);

        // Zero-gap instance: counter wrap and back-to-back spacing
        @(negedge user_clk);
        en = 1'b1;
        force dut_z.frm_cnt1_r = 32'hFFFF_FFFF;
        @(negedge user_clk);
        release dut_z.frm_cnt1_r;
        #1;
        chk_eq("z_cnt1_preload", z_frm_cnt1, 64'hFFFF_FFFF);
        @(negedge user_clk);
        z_s1_if.tvalid = 1'b1;
        z_s1_if.tdata  = 64'hA0A0_0000_0000_0001;
        z_s1_if.tkeep  = 8'hFF;
        z_s1_if.tlast  = 1'b0;
        #1;
        chk_eq("z_busy_req", z_busy, 64'd0);
        @(negedge user_clk);
        #1;
        chk_eq("z_busy_b0",  z_busy,          64'd1);
        chk_eq("z_grant",    z_grant,         64'd1);
        chk_eq("z_tdata_b0", z_m_if.tdata,    64'hA0A0_0000_0000_0001);
        chk_eq("z_s1_rdy",   z_s1_if.tready,  64'd1);
        chk_eq("z_s0_rdy",   z_s0_if.tready,  64'd0);
        @(negedge user_clk);
        z_s1_if.tdata = 64'hA0A0_0000_0000_0002;
        z_s1_if.tkeep = 8'h0F;
        z_s1_if.tlast = 1'b1;
        #1;
        chk_eq("z_tlast_b1", z_m_if.tlast, 64'd1);
        chk_eq("z_tkeep_b1", z_m_if.tkeep, 64'h0F);
        @(negedge user_clk);
        z_s1_if.tdata = 64'hB0B0_0000_0000_0001;
        z_s1_if.tkeep = 8'hFF;
        z_s1_if.tlast = 1'b1;
        #1;
        chk_eq("z_busy_gap",  z_busy,        64'd0);
        chk_eq("z_tvalid_gap", z_m_if.tvalid, 64'd0);
        chk_eq("z_cnt1_wrap", z_frm_cnt1,    64'd0);
        chk_eq("z_cnt0",      z_frm_cnt0,    64'd0);
        @(negedge user_clk);
        #1;
        chk_eq("z_busy_next", z_busy,       64'd1);
        chk_eq("z_tdata_next", z_m_if.tdata, 64'hB0B0_0000_0000_0001);
        @(negedge user_clk);
        z_s1_if.tvalid = 1'b0;
        #1;
        chk_eq("z_busy_end", z_busy,     64'd0);
        chk_eq("z_cnt1_one", z_frm_cnt1, 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
